r_sync_1x4: RTL and testbench
=============================

# r_sync_1x4

Synchronizer and control block of the 1x4 packet router. It latches the destination address of an incoming packet and steers the FSM's write strobe to one of four output FIFOs. It reports the addressed FIFO's full flag and drives per-port valid outputs from the FIFO empty flags. It also raises a per-port soft reset when a valid output is left unread for too long.

## Interface
- TIMEOUT, 30: consecutive unread-valid cycles before soft reset fires.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- data_in  in  2  destination address (0..3) of the current packet header.
- detect_add  in  1  header-detect strobe from the FSM; latch data_in.
- full_0..full_3  in  1 each  FIFO full flags.
- empty_0..empty_3  in  1 each  FIFO empty flags.
- write_enb_reg  in  1  FSM write request for the current packet.
- read_enb_0..read_enb_3  in  1 each  downstream read enables.
- write_enb  out  4  one-hot FIFO write enables.
- fifo_full  out  1  full flag of the addressed FIFO.
- vld_out_0..vld_out_3  out  1 each  output-valid per port.
- soft_reset_0..soft_reset_3  out  1 each  per-FIFO soft reset pulse.

## Operation
- Address register addr (2 b):
  - rst: addr <= 0.
  - else if detect_add: addr <= data_in.
  - else: hold.
- write_enb (combinational):
  - write_enb_reg=0 -> 4'b0000.
  - write_enb_reg=1 -> 1 << addr (addr 0 -> 0001, 1 -> 0010, 2 -> 0100, 3 -> 1000).
- fifo_full (combinational) = full_addr.
- vld_out_N = ~empty_N (combinational, independent of rst).
- Soft-reset timer, one per port, counter width 5 b. Qualifying cycle q_N = vld_out_N & ~read_enb_N.
  - rst: cnt <= 0, soft_reset_N <= 0.
  - else if ~q_N: cnt <= 0, soft_reset_N <= 0.
  - else if cnt == TIMEOUT-1: cnt <= 0, soft_reset_N <= 1.
  - else: cnt <= cnt+1, soft_reset_N <= 0.
- The four timers are fully independent; simultaneous firing is legal.

## Timing
- Address capture: addr takes effect the edge after detect_add is sampled high. write_enb and fifo_full reflect the new address in that same following cycle.
- If detect_add and write_enb_reg are high in the same cycle, write_enb still uses the old addr for that cycle.
- write_enb, fifo_full and vld_out have zero-cycle latency from their inputs.
- soft_reset_N rises after TIMEOUT (30) consecutive rising edges with q_N=1. It stays high for exactly one cycle, then the count restarts.
- If the condition persists, the pulse repeats every 30 cycles.
- Any cycle with q_N=0 (read_enb_N high or empty_N high) clears the count, so a 29-cycle stall produces no pulse.
- rst mid-count: the next edge clears cnt, soft_reset and addr. Outputs derived from addr become write_enb = 1 << 0 (when write_enb_reg=1) and fifo_full = full_0.
- Reset values: addr=0, all cnt=0, soft_reset_0..3=0. write_enb=0 when write_enb_reg=0; vld_out follows empty.

## Structure
- Shared package router_pkg:
  - NUM_PORTS=4
  - TIMEOUT=30
  - CNT_W=5
  - addr_t (logic [1:0])
- One sub-module r_sync_timeout: clk, rst, vld, read_enb -> soft_reset, instantiated four times.
- Top-level holds the address register, the one-hot decoder and the full mux.

## Test plan
- Reset then empty_0=1 for 10 cycles, then 0 -> vld_out_0=0 during the window and 1 after. Repeat for ports 1..3; all other vld_out unaffected.
- detect_add=1 with data_in=2'b01, then write_enb_reg=1 -> write_enb=4'b0010 from the next cycle. Then full_1=1 -> fifo_full=1; full_0=1 alone -> fifo_full=0.
- Sweep data_in 0..3 with write_enb_reg=1 -> write_enb = 0001/0010/0100/1000 and fifo_full tracks full_0..full_3. With write_enb_reg=0 -> write_enb=0000.
- empty_2=0, read_enb_2=0 for 30 cycles -> soft_reset_2 high for exactly one cycle on the 30th edge; other soft_resets stay 0.
- empty_0=0, read_enb_0=0 for 20 cycles, then read_enb_0=1 -> soft_reset_0 never asserts; the count restarts from 0.
- Assert rst while a count is at 25 and while addr=3 -> after the next edge cnt=0, soft_reset=0, addr=0 (write_enb=0001 with write_enb_reg=1).

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and types for the 1x4 router
package router_pkg;
  localparam int NUM_PORTS = 4;
  localparam int TIMEOUT   = 30;
  localparam int CNT_W     = 5;

  typedef logic [1:0] addr_t;
endpackage

// File: rtl/r_sync_timeout.sv
// rtl/r_sync_timeout.sv - per-port unread-valid watchdog producing a one-cycle soft reset
module r_sync_timeout
  import router_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic vld,
  input  logic read_enb,
  output logic soft_reset
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_soft_reset;
  logic             w_stall;

  assign w_stall = vld & ~read_enb;

  // The pulse fires on the edge that completes TIMEOUT stalled cycles; the count restarts with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b0;
    end else if (!w_stall) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b0;
    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b1;
    end else begin
      r_cnt        <= r_cnt + 1'b1;
      r_soft_reset <= 1'b0;
    end
  end

  assign soft_reset = r_soft_reset;

endmodule

// File: rtl/r_sync_1x4.sv
// rtl/r_sync_1x4.sv - router synchronizer: address latch, write steering, valid and soft-reset generation
module r_sync_1x4
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] data_in,
  input  logic       detect_add,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  input  logic       full_3,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       empty_3,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       read_enb_3,
  output logic [3:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       vld_out_3,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2,
  output logic       soft_reset_3
);

  addr_t                r_addr;
  logic [NUM_PORTS-1:0] w_full;
  logic [NUM_PORTS-1:0] w_vld;
  logic [NUM_PORTS-1:0] w_read;
  logic [NUM_PORTS-1:0] w_soft;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
    end else if (detect_add) begin
      r_addr <= data_in;
    end
  end

  assign w_full  = {full_3, full_2, full_1, full_0};
  assign w_vld   = ~{empty_3, empty_2, empty_1, empty_0};
  assign w_read  = {read_enb_3, read_enb_2, read_enb_1, read_enb_0};

  // Steering uses the registered address, so a header seen this cycle only affects the next one.
  assign write_enb = write_enb_reg ? (4'b0001 << r_addr) : 4'b0000;
  assign fifo_full = w_full[r_addr];

  assign vld_out_0 = w_vld[0];
  assign vld_out_1 = w_vld[1];
  assign vld_out_2 = w_vld[2];
  assign vld_out_3 = w_vld[3];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_timeout
    r_sync_timeout u_timeout (
      .clk        (clk),
      .rst        (rst),
      .vld        (w_vld[g]),
      .read_enb   (w_read[g]),
      .soft_reset (w_soft[g])
    );
  end

  assign soft_reset_0 = w_soft[0];
  assign soft_reset_1 = w_soft[1];
  assign soft_reset_2 = w_soft[2];
  assign soft_reset_3 = w_soft[3];

endmodule

// File: tb/tb_r_sync_1x4.sv
// tb/tb_r_sync_1x4.sv - self-checking bench for r_sync_1x4 against a run-length reference model
module tb_r_sync_1x4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] data_in = 2'd0;
  logic       detect_add = 1'b0;
  logic [3:0] full = 4'h0;
  logic [3:0] empty = 4'hF;
  logic       wr = 1'b0;
  logic [3:0] rd = 4'h0;

  wire  [3:0] write_enb;
  wire        fifo_full;
  wire  [3:0] vld_o;
  wire  [3:0] soft_o;

  int errors = 0;
  int checks = 0;

  // Reference state: latched address and consecutive stalled-cycle run length per port.
  int m_addr = 0;
  int run [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  r_sync_1x4 dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .detect_add    (detect_add),
    .full_0        (full[0]),
    .full_1        (full[1]),
    .full_2        (full[2]),
    .full_3        (full[3]),
    .empty_0       (empty[0]),
    .empty_1       (empty[1]),
    .empty_2       (empty[2]),
    .empty_3       (empty[3]),
    .write_enb_reg (wr),
    .read_enb_0    (rd[0]),
    .read_enb_1    (rd[1]),
    .read_enb_2    (rd[2]),
    .read_enb_3    (rd[3]),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out_0     (vld_o[0]),
    .vld_out_1     (vld_o[1]),
    .vld_out_2     (vld_o[2]),
    .vld_out_3     (vld_o[3]),
    .soft_reset_0  (soft_o[0]),
    .soft_reset_1  (soft_o[1]),
    .soft_reset_2  (soft_o[2]),
    .soft_reset_3  (soft_o[3])
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model at the edge, then check soft resets.
  task automatic tick();
    logic [3:0] exp_we;
    logic [3:0] exp_soft;
    #2;
    exp_we = wr ? (4'b0001 << m_addr) : 4'b0000;
    chk("write_enb", write_enb, exp_we);
    chk("fifo_full", {3'b000, fifo_full}, {3'b000, full[m_addr]});
    chk("vld_out", vld_o, ~empty);
    @(posedge clk);
    if (rst) begin
      m_addr = 0;
      for (int p = 0; p < 4; p++) run[p] = 0;
    end else begin
      if (detect_add) m_addr = int'(data_in);
      for (int p = 0; p < 4; p++) begin
        if (!empty[p] && !rd[p]) run[p] = run[p] + 1;
        else run[p] = 0;
      end
    end
    #1;
    for (int p = 0; p < 4; p++) exp_soft[p] = (run[p] != 0) && (run[p] % 30 == 0);
    chk("soft_reset", soft_o, exp_soft);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset state
    rst = 1'b1; empty = 4'hF; rd = 4'h0; wr = 1'b0;
    cycles(2);
    rst = 1'b0;
    wr = 1'b1;
    cycles(1);

    // Valid follows empty per port, others untouched
    wr = 1'b0; rd = 4'hF; empty = 4'h0;
    for (int p = 0; p < 4; p++) begin
      empty[p] = 1'b1;
      cycles(10);
      empty[p] = 1'b0;
      cycles(3);
    end

    // Header capture with simultaneous write: old address used this cycle
    detect_add = 1'b1; data_in = 2'b01; wr = 1'b1; full = 4'h0;
    cycles(1);
    detect_add = 1'b0;
    cycles(2);
    full = 4'b0010; cycles(1);
    full = 4'b0001; cycles(1);

    // Address sweep
    for (int a = 0; a < 4; a++) begin
      data_in = 2'(a); detect_add = 1'b1;
      cycles(1);
      detect_add = 1'b0;
      full = 4'(1 << a); cycles(1);
      full = ~full;      cycles(1);
      wr = 1'b0;         cycles(1);
      wr = 1'b1;
    end

    // Port 2 stall: pulse on the 30th edge and again 30 later
    rd = 4'h0; empty = 4'b1011;
    cycles(62);

    // Port 0: 20-cycle stall broken by a read, then a 29-cycle stall without pulse
    empty = 4'b1110;
    cycles(20);
    rd[0] = 1'b1; cycles(1);
    rd[0] = 1'b0; cycles(29);
    cycles(2);

    // Reset mid-count with addr = 3
    rd = 4'hF; data_in = 2'd3; detect_add = 1'b1; cycles(1);
    detect_add = 1'b0; rd = 4'h0; empty = 4'b1110;
    cycles(25);
    rst = 1'b1; wr = 1'b1; cycles(1);
    rst = 1'b0; cycles(35);

    // Randomized traffic with long stalls likely
    for (int i = 0; i < 900; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      detect_add = ($urandom_range(0, 7) == 0);
      data_in    = 2'($urandom_range(0, 3));
      wr         = 1'($urandom);
      full       = 4'($urandom);
      for (int p = 0; p < 4; p++) begin
        empty[p] = ($urandom_range(0, 63) == 0);
        rd[p]    = ($urandom_range(0, 47) == 0);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
